// File: rtl/step_ex_seq.sv
// step_ex_seq: execute-stage sequencer issuing one-cycle step enables and returning a wired ready pulse.
// Define STEP_EX_SEQ_TIMEOUT_EN to force completion with err after TIMEOUT wait cycles.
module step_ex_seq #(
  parameter int N_STEPS = 8,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena_,
  input  logic [SEL_W-1:0]   sel,
  output logic               rdy_,
  output logic [N_STEPS-1:0] step_ena_,
  input  logic               step_rdy_,
  output logic               busy,
  output logic               err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [SEL_W:0] NS_W = (SEL_W+1)'(N_STEPS);
  if (N_STEPS < 1 || N_STEPS > 2**SEL_W || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
    $error("step_ex_seq: parameter out of range");
  end
  state_t state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic busy_q, busy_d, err_q, err_d, sel_ok;
  assign sel_ok = {1'b0, sel} < NS_W;
`ifdef STEP_EX_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
  // Cleared while issuing so every WAIT visit starts from zero; saturates at TMO.
  always_comb cnt_d = (state_q == ISSUE) ? '0 :
                      (state_q == WAIT && step_rdy_ && cnt_q != TMO) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
`endif
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (!ena_) begin
        sel_d = sel;
        state_d = sel_ok ? ISSUE : DONE;
        err_d = err_q | !sel_ok;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (!step_rdy_) state_d = DONE;
`ifdef STEP_EX_SEQ_TIMEOUT_EN
      else if (cnt_d == TMO) begin
        state_d = DONE;
        err_d = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q <= '0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end
  assign step_ena_ = (state_q == ISSUE) ? ~(N_STEPS'(1) << sel_q) : '1;
  assign rdy_ = (state_q == DONE) ? 1'b0 : 1'bz;
  assign busy = busy_q;
  assign err = err_q;
endmodule

// File: tb/tb_step_ex_seq.sv
// tb_step_ex_seq: table-driven scoreboard bench for step_ex_seq with a 2-cycle model step unit.
module tb_step_ex_seq;
  localparam int NS = 6;
  localparam int TO = 15;
  typedef struct {logic [2:0] sel; logic [NS-1:0] mask; int lat; logic err;} vec_t;
  typedef struct {logic [NS-1:0] mask; int lat; logic err; int start;} exp_t;
  logic clk = 1'b0, rst = 1'b1, ena_ = 1'b1, unit_rdy_ = 1'b1, man_rdy_ = 1'b1, respond = 1'b1;
  logic [2:0] sel_i = '0;
  logic [NS-1:0] step_ena_, seen = '1;
  logic busy, err;
  wire rdy_w;
  wire step_rdy_w = unit_rdy_ & man_rdy_;
  pullup (rdy_w);
  int cyc = 0, checks = 0, failures = 0, pend = 0, nstrobe = 0, nbusy = 0;
  exp_t sb[$];
  vec_t tv[8];
  step_ex_seq #(.N_STEPS(NS), .SEL_W(3), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ena_(ena_), .sel(sel_i), .rdy_(rdy_w),
    .step_ena_(step_ena_), .step_rdy_(step_rdy_w), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Model unit: pulls step_rdy_ low for one cycle, two cycles after its strobe; also the scoreboard sink.
  always @(negedge clk) begin
    exp_t e;
    unit_rdy_ = !(pend == 1);
    if (pend > 0) pend--;
    if (step_ena_ != '1) begin
      nstrobe++;
      seen &= step_ena_;
      if (respond) pend = 2;
    end
    if (busy) nbusy++;
    if (rdy_w === 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_rdy: rdy_ low with no request outstanding (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc - e.start - 1, e.lat);
        chk("strobe_mask", int'(seen), int'(e.mask));
        chk("strobe_count", nstrobe, (e.mask != '1) ? 1 : 0);
        chk("busy_cycles", nbusy, e.lat + 1);
        chk("err_at_done", int'(err), int'(e.err));
      end
      nstrobe = 0;
      nbusy = 0;
      seen = '1;
    end
  end
  task automatic chk_idle();
    chk("idle_rdy_released", int'(rdy_w === 1'b1), 1);
    chk("idle_step_ena", int'(step_ena_), 'h3F);
    chk("idle_busy", int'(busy), 0);
    chk("idle_err", int'(err), 0);
  endtask
  task automatic clear_mon();
    #1;
    nstrobe = 0;
    nbusy = 0;
    seen = '1;
    sb.delete();
  endtask
  task automatic run_op(input logic [2:0] s, input logic [NS-1:0] m, input int lat, input logic e, input int inj);
    int n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_before_start", int'(busy), 0);
    ena_ = 1'b0;
    sel_i = s;
    sb.push_back('{m, lat, e, cyc});
    @(negedge clk);
    ena_ = 1'b1;
    if (inj > 0) begin
      for (int k = 1; k < inj; k++) @(negedge clk);
      ena_ = 1'b0;
      sel_i = 3'd5;
      @(negedge clk);
      ena_ = 1'b1;
    end
    n = 0;
    #1;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("op_completed", sb.size(), 0);
    sb.delete();
    @(negedge clk);
    chk("rdy_single_pulse", int'(rdy_w === 1'b1), 1);
    chk("idle_after_op", int'(busy), 0);
  endtask
  initial begin
    int bad;
    tv[0] = '{3'd0, 6'h3E, 3, 1'b0};
    tv[1] = '{3'd1, 6'h3D, 3, 1'b0};
    tv[2] = '{3'd2, 6'h3B, 3, 1'b0};
    tv[3] = '{3'd4, 6'h2F, 3, 1'b0};
    tv[4] = '{3'd7, 6'h3F, 0, 1'b1};
    tv[5] = '{3'd6, 6'h3F, 0, 1'b1};
    tv[6] = '{3'd3, 6'h37, 3, 1'b1};
    tv[7] = '{3'd5, 6'h1F, 3, 1'b1};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_idle();
    end
    run_op(3'd3, 6'h37, 3, 1'b0, 2);
    run_op(3'd5, 6'h1F, 3, 1'b0, 0);
    for (int i = 0; i < 8; i++) run_op(tv[i].sel, tv[i].mask, tv[i].lat, tv[i].err, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    @(negedge clk);
    chk_idle();
    respond = 1'b0;
`ifdef STEP_EX_SEQ_TIMEOUT_EN
    run_op(3'd4, 6'h2F, TO + 1, 1'b1, 0);
`endif
    @(negedge clk);
    ena_ = 1'b0;
    sel_i = 3'd4;
    @(negedge clk);
    ena_ = 1'b1;
`ifdef STEP_EX_SEQ_TIMEOUT_EN
    @(negedge clk);
`else
    bad = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (!busy || rdy_w !== 1'b1) bad++;
    end
    chk("hang_busy_no_rdy", bad, 0);
`endif
    chk("wait_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    man_rdy_ = 1'b0;
    respond = 1'b1;
    clear_mon();
    @(negedge clk);
    man_rdy_ = 1'b1;
    chk_idle();
    repeat (3) begin
      @(negedge clk);
      chk_idle();
    end
    run_op(3'd0, 6'h3E, 3, 1'b0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
